mdr_mem_interface: RTL and testbench

Memory Address Register (MAR), Memory Data Register (MDR) and memory-handshake sequencer for the datapath. It sits directly upstream of the bus multiplexer and drives the multiplexer's MDR input. It captures addresses and store data from the shared bus output. It runs a request/acknowledge transaction with external RAM and supports an arbitrary number of wait states. It signals completion to the control unit with a one-cycle pulse.

---
 rtl/mem_if_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/mdr_mem_interface.sv | 151 +++++++++++++++
 tb/tb_mdr_mem_interface.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Shared FSM state type and default sizing constants for mdr_mem_interface.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_if_pkg;

  // Handshake sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_e;

  // Default MAR / RAM address width
  localparam int MEM_ADDR_W  = 9;

  // Default wait-state limit (cycles), legal 1..255
  localparam int MEM_TIMEOUT = 15;

endpackage : mem_if_pkg

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Wait-state counter: held at zero by start, advances on tick, flags expiry
// during the tick cycle in which the TIMEOUT-th wait cycle completes.
// Only instantiated when MDR_MEM_TIMEOUT_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  // Count wait cycles; start keeps the counter at zero outside a transaction
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  // Count holds the number of completed wait cycles, so the current cycle is
  // the TIMEOUT-th one when count equals TIMEOUT-1
  assign expired = tick && (count == 8'(TIMEOUT - 1));

endmodule : mem_wait_timer

`default_nettype wire

// File: rtl/mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// mdr_mem_interface
// MAR/MDR registers and RAM request/acknowledge sequencer with arbitrary
// wait states and a one-cycle completion pulse.
// Optional wait-state timeout: define MDR_MEM_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdr_mem_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       BusMuxInMDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);

  mem_state_e        state;
  mem_state_e        next_state;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  logic              waiting;
  logic              timed_out;
  logic              err_q;

  // Reject out-of-range wait limits at elaboration
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mdr_mem_interface: TIMEOUT must be within 1..255");
  end

  assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef MDR_MEM_TIMEOUT_EN
  logic expired;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .start   (!waiting),
    .tick    (waiting),
    .expired (expired)
  );

  // An ack on the expiry edge wins over the timeout
  assign timed_out = expired && !mem_ack;

  // Error flag is raised only for the DONE cycle that follows a timeout
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= waiting && timed_out;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err_q     = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; read has priority over write, DONE ignores all inputs
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Read) begin
          next_state = RD_WAIT;
        end else if (Write) begin
          next_state = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack || timed_out) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MAR/MDR: loadable only in IDLE, MDR captures read data on the ack edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MARin) begin
            mar <= BusMuxOut[ADDR_W-1:0];
          end
          if (MDRin && !Read) begin
            mdr <= BusMuxOut;
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mdr <= mem_rdata;
          end
        end
        default: begin
          mar <= mar;
          mdr <= mdr;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_req     = waiting;
    mem_we      = (state == WR_WAIT);
    mem_busy    = (state != IDLE);
    mem_done    = (state == DONE);
    mem_err     = err_q;
    mem_addr    = mar;
    mem_wdata   = mdr;
    BusMuxInMDR = mdr;
  end

endmodule : mdr_mem_interface

`default_nettype wire

// File: tb/tb_mdr_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mdr_mem_interface
// Self-checking bench for mdr_mem_interface: directed scenarios plus random
// transactions checked against a transaction-level reference model.
// Honours MDR_MEM_TIMEOUT_EN for the timeout / indefinite-wait scenario.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mdr_mem_interface;

  localparam int TMO = 15;

  logic        clock;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin;
  logic        MDRin;
  logic        Read;
  logic        Write;
  logic [31:0] BusMuxInMDR;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural MAR and MDR contents
  logic [8:0]  mar_m;
  logic [31:0] mdr_m;

  mdr_mem_interface dut (
    .clock       (clock),
    .clear       (clear),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .BusMuxInMDR (BusMuxInMDR),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done),
    .mem_err     (mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    MARin   = 1'b0;
    MDRin   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, mem_busy, 0);
    chk({tag, ".req"},  mem_req,  0);
    chk({tag, ".done"}, mem_done, 0);
    chk({tag, ".err"},  mem_err,  0);
    chk({tag, ".addr"}, mem_addr, mar_m);
    chk({tag, ".wdata"}, mem_wdata, mdr_m);
    chk({tag, ".mdr"},  BusMuxInMDR, mdr_m);
  endtask

  // Drive random bus-load and control noise
  task automatic drive_junk();
    BusMuxOut = $urandom;
    MARin     = 1'($urandom);
    MDRin     = 1'($urandom);
    Read      = 1'($urandom);
    Write     = 1'($urandom);
  endtask

  // One complete transaction; caller is just past a negedge with DUT idle.
  // Acknowledge arrives after w wait cycles (w=0: ack in first request cycle).
  task automatic run_txn(input bit is_read, input bit also_write, input int w,
                         input logic [31:0] rdata, input bit junk);
    BusMuxOut = $urandom;
    MARin     = junk ? 1'($urandom) : 1'b0;
    MDRin     = junk ? 1'($urandom) : 1'b0;
    Read      = is_read;
    Write     = !is_read || also_write;
    mem_ack   = 1'b0;
    if (MARin) mar_m = BusMuxOut[8:0];
    if (MDRin && !is_read) mdr_m = BusMuxOut;
    for (int i = 0; i <= w; i++) begin
      @(negedge clock);
      chk("wait.req",   mem_req,  1);
      chk("wait.we",    mem_we,   !is_read);
      chk("wait.busy",  mem_busy, 1);
      chk("wait.done",  mem_done, 0);
      chk("wait.addr",  mem_addr, mar_m);
      chk("wait.wdata", mem_wdata, mdr_m);
      if (junk) drive_junk(); else idle_inputs();
      mem_ack   = (i == w);
      mem_rdata = (i == w) ? rdata : $urandom;
    end
    @(negedge clock);
    if (is_read) mdr_m = rdata;
    chk("done.done", mem_done, 1);
    chk("done.err",  mem_err,  0);
    chk("done.req",  mem_req,  0);
    chk("done.busy", mem_busy, 1);
    chk("done.mdr",  BusMuxInMDR, mdr_m);
    chk("done.addr", mem_addr, mar_m);
    if (junk) begin
      drive_junk();
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
    end else begin
      idle_inputs();
    end
    @(negedge clock);
    check_idle("after_done");
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    clear     = 1'b1;
    BusMuxOut = '0;
    mem_rdata = '0;
    idle_inputs();
    mar_m = '0;
    mdr_m = '0;
    #3 clear = 1'b0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst.req",  mem_req,  0);
    chk("rst.we",   mem_we,   0);
    chk("rst.busy", mem_busy, 0);
    chk("rst.done", mem_done, 0);
    chk("rst.err",  mem_err,  0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.mdr",  BusMuxInMDR, 0);
    clear = 1'b1;
    @(negedge clock);

    // Zero-wait read: MARin and Read together, ack in first request cycle
    BusMuxOut = 32'h0000_0042;
    MARin = 1'b1;
    Read  = 1'b1;
    mar_m = 9'h042;
    @(negedge clock);
    idle_inputs();
    chk("zw.req",  mem_req,  1);
    chk("zw.we",   mem_we,   0);
    chk("zw.addr", mem_addr, 9'h042);
    chk("zw.done_early", mem_done, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    mem_ack = 1'b0;
    mdr_m   = 32'hDEAD_BEEF;
    chk("zw.done", mem_done, 1);
    chk("zw.mdr",  BusMuxInMDR, 32'hDEAD_BEEF);
    chk("zw.req_off", mem_req, 0);
    @(negedge clock);
    check_idle("zw.after");

    // Write with 4 wait states after loading MDR
    BusMuxOut = 32'h1234_5678;
    MDRin = 1'b1;
    mdr_m = 32'h1234_5678;
    @(negedge clock);
    idle_inputs();
    check_idle("wr.load");
    run_txn(1'b0, 1'b0, 4, 32'hBAD0_BAD0, 1'b0);
    chk("wr.mdr_kept", BusMuxInMDR, 32'h1234_5678);

    // Read and Write together plus bus loads during the wait: read wins
    run_txn(1'b1, 1'b1, 2, 32'hCAFE_F00D, 1'b1);

    // Reset in the middle of a read, followed by a stale ack
    run_txn(1'b1, 1'b0, 0, 32'h5555_AAAA, 1'b0);
    Read = 1'b1;
    @(negedge clock);
    Read = 1'b0;
    chk("mid.req", mem_req, 1);
    #2 clear = 1'b0;
    #1;
    mar_m = '0;
    mdr_m = '0;
    chk("mid.req0",  mem_req,  0);
    chk("mid.we0",   mem_we,   0);
    chk("mid.busy0", mem_busy, 0);
    chk("mid.done0", mem_done, 0);
    chk("mid.err0",  mem_err,  0);
    chk("mid.addr0", mem_addr, 0);
    chk("mid.mdr0",  BusMuxInMDR, 0);
    @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    check_idle("mid.after");

    // Give MDR a known prior value, then a read that never gets an ack in time
    BusMuxOut = 32'hA5A5_0F0F;
    MDRin = 1'b1;
    mdr_m = 32'hA5A5_0F0F;
    @(negedge clock);
    idle_inputs();
    Read = 1'b1;
    @(negedge clock);
    Read = 1'b0;
`ifdef MDR_MEM_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      chk("to.req",  mem_req,  1);
      chk("to.done", mem_done, 0);
      @(negedge clock);
    end
    chk("to.done16", mem_done, 1);
    chk("to.err16",  mem_err,  1);
    chk("to.req16",  mem_req,  0);
    chk("to.mdr",    BusMuxInMDR, mdr_m);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clock);
    check_idle("to.late1");
    @(negedge clock);
    mem_ack = 1'b0;
    check_idle("to.late2");
`else
    for (int i = 1; i <= 100; i++) begin
      chk("inf.req",  mem_req,  1);
      chk("inf.done", mem_done, 0);
      chk("inf.err",  mem_err,  0);
      @(negedge clock);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h0600_D0D0;
    @(negedge clock);
    mem_ack = 1'b0;
    mdr_m   = 32'h0600_D0D0;
    chk("inf.done", mem_done, 1);
    chk("inf.err",  mem_err,  0);
    chk("inf.mdr",  BusMuxInMDR, mdr_m);
    @(negedge clock);
    check_idle("inf.after");
`endif

    // Random transactions separated by random idle-cycle register loads
    for (int t = 0; t < 30; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        BusMuxOut = $urandom;
        MARin     = 1'($urandom);
        MDRin     = 1'($urandom);
        Read      = 1'b0;
        Write     = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        if (MARin) mar_m = BusMuxOut[8:0];
        if (MDRin) mdr_m = BusMuxOut;
        @(negedge clock);
        check_idle("rnd.idle");
      end
      idle_inputs();
      v = $urandom;
      run_txn(1'($urandom), 1'($urandom), $urandom_range(0, 6), v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mdr_mem_interface

`default_nettype wire
